// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchronizer, stable-window debounce FSM and edge pulses for one switch input.
// Optional auto-repeat of rise_pulse while held: define AUTO_REPEAT_EN.
module switch_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic CLK50M,
    input  logic reset,
    input  logic A_noisy,
    output logic A,
    output logic rise_pulse,
    output logic fall_pulse,
    output logic busy
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    generate
        if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || DEBOUNCE_CYCLES < 2 ||
            REPEAT_PERIOD < 1 || REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_params
            $error("switch_conditioner: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_out;
    state_t                 state_q;
    logic [CW-1:0]          cnt_q;
    logic                   a_q;
    logic                   rise_q;
    logic                   fall_q;
    logic                   busy_q;

    assign sync_out = sync_q[SYNC_STAGES-1];

    always_ff @(posedge CLK50M) begin
        if (reset) begin
            sync_q  <= '0;
            state_q <= IDLE_LOW;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], A_noisy};
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            case (state_q)
                IDLE_LOW: begin
                    if (sync_out) begin
                        state_q <= WAIT_HIGH;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_HIGH: begin
                    if (!sync_out) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        a_q     <= 1'b1;
                        rise_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                IDLE_HIGH: begin
                    if (!sync_out) begin
                        state_q <= WAIT_LOW;
                        cnt_q   <= CNT_ONE;
                        busy_q  <= 1'b1;
                    end else begin
                        cnt_q <= '0;
                    end
                end
                WAIT_LOW: begin
                    if (sync_out) begin
                        state_q <= IDLE_HIGH;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE_LOW;
                        cnt_q   <= '0;
                        a_q     <= 1'b0;
                        fall_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_ONE;
                    end
                end
                default: begin
                    state_q <= IDLE_LOW;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUTO_REPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rpt_q;
    logic          rpt_pulse_q;

    // Cleared on every entry into IDLE_HIGH; frozen while WAIT_LOW qualifies a release.
    // Reloading to DELAY-PERIOD after a fire makes later pulses PERIOD apart.
    always_ff @(posedge CLK50M) begin
        if (reset) begin
            rpt_q       <= '0;
            rpt_pulse_q <= 1'b0;
        end else begin
            rpt_pulse_q <= 1'b0;
            if (state_q == WAIT_HIGH || (state_q == WAIT_LOW && sync_out)) begin
                rpt_q <= '0;
            end else if (state_q == IDLE_HIGH && sync_out) begin
                if (rpt_q == RPT_LAST) begin
                    rpt_q       <= RPT_RELOAD;
                    rpt_pulse_q <= 1'b1;
                end else begin
                    rpt_q <= rpt_q + RW'(1);
                end
            end
        end
    end

    assign rise_pulse = rise_q | rpt_pulse_q;
`else
    assign rise_pulse = rise_q;
`endif

    assign A          = a_q;
    assign fall_pulse = fall_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - cycle-vector bench for switch_conditioner (SYNC=2, DEBOUNCE=8, REPEAT 20/5).
module tb_switch_conditioner;

    logic clk = 1'b0;
    logic reset;
    logic a_noisy;
    logic a_out;
    logic rise;
    logic fall;
    logic busy;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    switch_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(8),
        .REPEAT_DELAY   (20),
        .REPEAT_PERIOD  (5)
    ) dut (
        .CLK50M    (clk),
        .reset     (reset),
        .A_noisy   (a_noisy),
        .A         (a_out),
        .rise_pulse(rise),
        .fall_pulse(fall),
        .busy      (busy)
    );

    typedef struct {
        logic rst;
        logic a;
        logic ea;
        logic er;
        logic ef;
        logic eb;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input int n, input logic rst, input logic a,
                        input logic ea, input logic er, input logic ef, input logic eb);
        vec_t v;
        v.rst = rst; v.a = a; v.ea = ea; v.er = er; v.ef = ef; v.eb = eb;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    // Drive inputs, take one rising edge, sample 1 time unit later.
    task automatic step(input logic rst, input logic a,
                        input logic ea, input logic er, input logic ef, input logic eb,
                        input string name, input int idx);
        reset   = rst;
        a_noisy = a;
        @(posedge clk);
        #1;
        n_vec++;
        if ({a_out, rise, fall, busy} !== {ea, er, ef, eb}) begin
            n_bad++;
            $display("FAIL %s[%0d]: got A/rise/fall/busy=%b%b%b%b, expected %b%b%b%b",
                     name, idx, a_out, rise, fall, busy, ea, er, ef, eb);
        end
    endtask

    initial begin
        logic exp_r;
        reset   = 1'b1;
        a_noisy = 1'b0;

        // Reset state.
        push(2, 1, 0, 0, 0, 0, 0);
        // Clean press: busy from edge 3, A and rise_pulse after edge 10.
        push(2, 0, 1, 0, 0, 0, 0);
        push(7, 0, 1, 0, 0, 0, 1);
        push(1, 0, 1, 1, 1, 0, 0);
        push(1, 0, 1, 1, 0, 0, 0);
        // Release: low 3, high 2, low held; fall 10 edges after final falling input.
        push(2, 0, 0, 1, 0, 0, 0);
        push(1, 0, 0, 1, 0, 0, 1);
        push(2, 0, 1, 1, 0, 0, 1);
        push(2, 0, 0, 1, 0, 0, 0);
        push(7, 0, 0, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 1, 0);
        push(1, 0, 0, 0, 0, 0, 0);
        // Bounce reject: high 5, low 1, high 5, low.
        push(2, 0, 1, 0, 0, 0, 0);
        push(3, 0, 1, 0, 0, 0, 1);
        push(1, 0, 0, 0, 0, 0, 1);
        push(1, 0, 1, 0, 0, 0, 1);
        push(1, 0, 1, 0, 0, 0, 0);
        push(3, 0, 1, 0, 0, 0, 1);
        push(2, 0, 0, 0, 0, 0, 1);
        push(2, 0, 0, 0, 0, 0, 0);
        // Reset at cnt=4 in WAIT_HIGH, input stays high.
        push(2, 0, 1, 0, 0, 0, 0);
        push(4, 0, 1, 0, 0, 0, 1);
        push(1, 1, 1, 0, 0, 0, 0);
        push(2, 0, 1, 0, 0, 0, 0);
        push(7, 0, 1, 0, 0, 0, 1);
        push(1, 0, 1, 1, 1, 0, 0);
        push(1, 0, 1, 1, 0, 0, 0);
        // Reset held with input high from A=1, then normal rise.
        push(3, 1, 1, 0, 0, 0, 0);
        push(2, 0, 1, 0, 0, 0, 0);
        push(7, 0, 1, 0, 0, 0, 1);
        push(1, 0, 1, 1, 1, 0, 0);
        push(5, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].a, vecs[i].ea, vecs[i].er, vecs[i].ef, vecs[i].eb, "vec", i);

        // Long hold: auto-repeat pulses at +20, +25, ... after A rises, or none.
        step(1, 1, 0, 0, 0, 0, "hold_rst", 0);
        for (int k = 1; k <= 10; k++)
            step(0, 1, (k == 10), (k == 10), 0, (k >= 3 && k <= 9), "hold_press", k);
        for (int k = 1; k <= 50; k++) begin
`ifdef AUTO_REPEAT_EN
            exp_r = (k >= 20) && ((k - 20) % 5 == 0);
`else
            exp_r = 1'b0;
`endif
            step(0, 1, 1, exp_r, 0, 0, "hold_repeat", k);
        end
        // Release after the long hold still yields exactly one fall.
        for (int k = 1; k <= 11; k++)
            step(0, 0, (k < 10), 0, (k == 10), (k >= 3 && k <= 9), "hold_release", k);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
